// File: rtl/rv32_decode_stage_pkg.sv
// Shared RV32 decode definitions: opcodes, funct7 codes, instruction classes,
// skid-buffer states and the decoded-record layout.
package rv32_decode_stage_pkg;

    // Decoded records carry the PC zero-extended to this width.
    localparam int PC_MAX_W = 64;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [3:0] {
        CLS_UNKNOWN,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OP_IMM,
        CLS_OP,
        CLS_MISC_MEM,
        CLS_SYSTEM
    } cls_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_e;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        cls_e                cls;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [31:0]         imm;
        logic                rd_we;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32 immediate generator; format chosen by opcode, always
// sign-extended from instruction bit 31.
module rv32_imm_gen
    import rv32_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: decodes each word at acceptance and holds the decoded
// records in a 2-entry skid buffer with a registered in_ready.
module rv32_decode_stage
    import rv32_decode_stage_pkg::*;
#(
    parameter bit EN_M      = 1'b0,
    parameter bit EN_SYSTEM = 1'b1,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output dec_t            out_dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        illegal;
    cls_e        cls;
    dec_t        dec_in;

    state_e state_q, state_d;
    dec_t   head_q, head_d;
    dec_t   tail_q, tail_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, present;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    rv32_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    always_comb begin
        cls     = CLS_UNKNOWN;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR: begin
                cls     = CLS_JALR;
                illegal = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                cls     = CLS_BRANCH;
                illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LOAD: begin
                cls     = CLS_LOAD;
                illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                cls     = CLS_STORE;
                illegal = (f3 > 3'd2);
            end
            OPC_OP_IMM: begin
                cls = CLS_OP_IMM;
                // Shift-immediates reuse funct7 as an opcode extension.
                if (f3 == 3'd1)
                    illegal = (f7 != F7_BASE);
                else if (f3 == 3'd5)
                    illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            OPC_OP: begin
                cls = CLS_OP;
                case (f7)
                    F7_BASE:   illegal = 1'b0;
                    F7_ALT:    illegal = (f3 != 3'd0) && (f3 != 3'd5);
                    F7_MULDIV: illegal = !EN_M;
                    default:   illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                cls     = CLS_MISC_MEM;
                illegal = !EN_SYSTEM;
            end
            OPC_SYSTEM: begin
                cls     = CLS_SYSTEM;
                illegal = !EN_SYSTEM;
            end
            default: begin
                cls     = CLS_UNKNOWN;
                illegal = 1'b1;
            end
        endcase
        if (in_instr[1:0] != 2'b11)
            illegal = 1'b1;
    end

    always_comb begin
        dec_in         = '0;
        dec_in.pc      = PC_MAX_W'(in_pc);
        dec_in.cls     = cls;
        dec_in.rd      = in_instr[11:7];
        dec_in.rs1     = in_instr[19:15];
        dec_in.rs2     = in_instr[24:20];
        dec_in.funct3  = f3;
        dec_in.funct7  = f7;
        dec_in.imm     = imm;
        dec_in.illegal = illegal;
        dec_in.rd_we   = !illegal && (in_instr[11:7] != 5'd0)
                       && !(cls inside {CLS_STORE, CLS_BRANCH, CLS_MISC_MEM});
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_dec   = head_q;
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q && !flush;
    assign present   = out_valid && out_ready;

    // Head is always the presented entry; tail only fills while head is stalled.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = dec_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && present) begin
                    head_d = dec_in;
                end else if (accept) begin
                    tail_d  = dec_in;
                    state_d = ST_TWO;
                end else if (present) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (present) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush)
            state_d = ST_EMPTY;
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: stored records are reset too, so out_dec reads all-zero rather than X after reset.
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Self-checking bench for rv32_decode_stage: decode vector table, handshake
// corner sequences and randomized traffic against a queue-based reference model.
module tb_rv32_decode_stage;
    import rv32_decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    dec_t        dec0, dec1;

    int n_checks = 0;
    int n_fail   = 0;

    dec_t        q0[$];
    dec_t        q1[$];
    logic [31:0] emitted[$];
    bit          m_rdy = 1'b0;
    bit          acc;

    typedef struct {
        logic [31:0] instr;
        cls_e        cls;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        we0, ill0, we1, ill1;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    rv32_decode_stage dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid0), .out_ready(out_ready), .out_dec(dec0)
    );

    rv32_decode_stage #(.EN_M(1'b1), .EN_SYSTEM(1'b0), .PC_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid1), .out_ready(out_ready), .out_dec(dec1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediates rebuilt arithmetically from their bit-field weights.
    function automatic logic [31:0] imm_i(logic [31:0] w);
        return 32'((w[31] ? -2048 : 0) + int'(w[30:20]));
    endfunction
    function automatic logic [31:0] imm_s(logic [31:0] w);
        return 32'((w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]));
    endfunction
    function automatic logic [31:0] imm_b(logic [31:0] w);
        return 32'((w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
    endfunction
    function automatic logic [31:0] imm_j(logic [31:0] w);
        return 32'((w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                   + int'(w[30:21]) * 2);
    endfunction

    function automatic dec_t model(logic [31:0] w, logic [31:0] pc, bit en_m, bit en_sys);
        dec_t r;
        int   f3, f7;
        bit   bad;
        r = '0;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        bad = 1'b0;
        r.pc = {32'b0, pc};
        r.rd = w[11:7];
        r.rs1 = w[19:15];
        r.rs2 = w[24:20];
        r.funct3 = w[14:12];
        r.funct7 = w[31:25];
        case (w[6:0])
            OPC_LUI:      begin r.cls = CLS_LUI;   r.imm = w & 32'hFFFF_F000; end
            OPC_AUIPC:    begin r.cls = CLS_AUIPC; r.imm = w & 32'hFFFF_F000; end
            OPC_JAL:      begin r.cls = CLS_JAL;   r.imm = imm_j(w); end
            OPC_JALR:     begin r.cls = CLS_JALR;  r.imm = imm_i(w); bad = (f3 != 0); end
            OPC_BRANCH:   begin r.cls = CLS_BRANCH; r.imm = imm_b(w); bad = f3 inside {2, 3}; end
            OPC_LOAD:     begin r.cls = CLS_LOAD;  r.imm = imm_i(w); bad = f3 inside {3, 6, 7}; end
            OPC_STORE:    begin r.cls = CLS_STORE; r.imm = imm_s(w); bad = (f3 > 2); end
            OPC_OP_IMM: begin
                r.cls = CLS_OP_IMM;
                r.imm = imm_i(w);
                bad = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {0, 32}));
            end
            OPC_OP: begin
                r.cls = CLS_OP;
                bad = !((f7 == 0) || (f7 == 32 && f3 inside {0, 5}) || (f7 == 1 && en_m));
            end
            OPC_MISC_MEM: begin r.cls = CLS_MISC_MEM; bad = !en_sys; end
            OPC_SYSTEM:   begin r.cls = CLS_SYSTEM;   bad = !en_sys; end
            default:      begin r.cls = CLS_UNKNOWN;  bad = 1'b1; end
        endcase
        if (w[1:0] != 2'b11) bad = 1'b1;
        r.illegal = bad;
        r.rd_we = !bad && (w[11:7] != 0) && !(r.cls inside {CLS_STORE, CLS_BRANCH, CLS_MISC_MEM});
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 10))
                0: w[6:0] = OPC_LUI;     1: w[6:0] = OPC_AUIPC;    2: w[6:0] = OPC_JAL;
                3: w[6:0] = OPC_JALR;    4: w[6:0] = OPC_BRANCH;   5: w[6:0] = OPC_LOAD;
                6: w[6:0] = OPC_STORE;   7: w[6:0] = OPC_OP_IMM;   8: w[6:0] = OPC_OP;
                9: w[6:0] = OPC_MISC_MEM; default: w[6:0] = OPC_SYSTEM;
            endcase
            if ((w[6:0] == OPC_OP || w[6:0] == OPC_OP_IMM) && $urandom_range(0, 3) != 0)
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: w[31:25] = 7'h01;
                endcase
        end
        return w;
    endfunction

    task automatic check_outputs();
        check("in_ready0", 128'(in_ready0), 128'(m_rdy));
        check("in_ready1", 128'(in_ready1), 128'(m_rdy));
        check("out_valid0", 128'(out_valid0), 128'(q0.size() != 0));
        check("out_valid1", 128'(out_valid1), 128'(q1.size() != 0));
        if (q0.size() != 0) begin
            check("out_dec0", 128'(dec0), 128'(q0[0]));
            check("out_dec1", 128'(dec1), 128'(q1[0]));
        end
    endtask

    // One clock: check at the falling edge, then advance the model past the rising edge.
    task automatic cycle(output bit accepted);
        bit pres;
        @(negedge clk);
        check_outputs();
        if (out_valid0 && out_ready) emitted.push_back(dec0.pc[31:0]);
        accepted = rst_n && in_valid && m_rdy && !flush;
        pres = rst_n && (q0.size() != 0) && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_rdy = 1'b0;
        end else begin
            if (pres) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (flush) begin
                q0.delete();
                q1.delete();
            end else if (accepted) begin
                q0.push_back(model(in_instr, in_pc, 1'b0, 1'b1));
                q1.push_back(model(in_instr, in_pc, 1'b1, 1'b0));
            end
            m_rdy = (q0.size() != 2);
        end
        #1;
    endtask

    task automatic add_vec(logic [31:0] instr, cls_e cls, logic [4:0] rd, logic [31:0] imm,
                           logic we0, logic ill0, logic we1, logic ill1);
        vec_t v;
        v.instr = instr; v.cls = cls; v.rd = rd; v.imm = imm;
        v.we0 = we0; v.ill0 = ill0; v.we1 = we1; v.ill1 = ill1;
        vecs.push_back(v);
    endtask

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //      instr         class         rd     imm           we0 ill0 we1 ill1
        add_vec(32'h00500093, CLS_OP_IMM,   5'd1,  32'd5,        1, 0, 1, 0); // addi x1,x0,5
        add_vec(32'hFE000EE3, CLS_BRANCH,   5'd29, 32'hFFFFFFFC, 0, 0, 0, 0); // beq -4
        add_vec(32'h02208033, CLS_OP,       5'd0,  32'd0,        0, 1, 0, 0); // mul x0,x1,x2
        add_vec(32'h402081B3, CLS_OP,       5'd3,  32'd0,        1, 0, 1, 0); // sub
        add_vec(32'h4020C1B3, CLS_OP,       5'd3,  32'd0,        0, 1, 0, 1); // funct7 0x20, funct3 4
        add_vec(32'h123452B7, CLS_LUI,      5'd5,  32'h12345000, 1, 0, 1, 0);
        add_vec(32'hFE20AC23, CLS_STORE,    5'd24, 32'hFFFFFFF8, 0, 0, 0, 0); // sw x2,-8(x1)
        add_vec(32'h008000EF, CLS_JAL,      5'd1,  32'd8,        1, 0, 1, 0);
        add_vec(32'h0FF0000F, CLS_MISC_MEM, 5'd0,  32'd0,        0, 0, 0, 1); // fence
        add_vec(32'h00000073, CLS_SYSTEM,   5'd0,  32'd0,        0, 0, 0, 1); // ecall
        add_vec(32'h30002573, CLS_SYSTEM,   5'd10, 32'd0,        1, 0, 0, 1); // csrrs
        add_vec(32'h00500090, CLS_UNKNOWN,  5'd1,  32'd0,        0, 1, 0, 1); // low bits != 11
        add_vec(32'h00003083, CLS_LOAD,     5'd1,  32'd0,        0, 1, 0, 1); // load funct3 3
        add_vec(32'h000010E7, CLS_JALR,     5'd1,  32'd0,        0, 1, 0, 1); // jalr funct3 1
        add_vec(32'h40109093, CLS_OP_IMM,   5'd1,  32'h401,      0, 1, 0, 1); // slli bad funct7
        add_vec(32'h4010D093, CLS_OP_IMM,   5'd1,  32'h401,      1, 0, 1, 0); // srai
        add_vec(32'h00002063, CLS_BRANCH,   5'd0,  32'd0,        0, 1, 0, 1); // branch funct3 2
        add_vec(32'h00003023, CLS_STORE,    5'd0,  32'd0,        0, 1, 0, 1); // store funct3 3

        // Reset state, then in_ready rises one edge after release.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(out_valid0), 128'(0));
        check("rst_in_ready", 128'(in_ready0), 128'(0));
        check("rst_out_dec", 128'(dec0), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(acc);
        check("post_rst_in_ready", 128'(in_ready0), 128'(1));

        // Decode table, one word at a time.
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h1000 + 32'(i) * 4;
            cycle(acc);
            in_valid = 1'b0;
            check($sformatf("tbl%0d_valid", i), 128'(out_valid0), 128'(1));
            check($sformatf("tbl%0d_cls", i), 128'(dec0.cls), 128'(vecs[i].cls));
            check($sformatf("tbl%0d_rd", i), 128'(dec0.rd), 128'(vecs[i].rd));
            check($sformatf("tbl%0d_imm", i), 128'(dec0.imm), 128'(vecs[i].imm));
            check($sformatf("tbl%0d_we0", i), 128'(dec0.rd_we), 128'(vecs[i].we0));
            check($sformatf("tbl%0d_ill0", i), 128'(dec0.illegal), 128'(vecs[i].ill0));
            check($sformatf("tbl%0d_we1", i), 128'(dec1.rd_we), 128'(vecs[i].we1));
            check($sformatf("tbl%0d_ill1", i), 128'(dec1.illegal), 128'(vecs[i].ill1));
            cycle(acc);
        end

        // Back-to-back words at full rate.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc    = 32'h2000 + 32'(i) * 4;
            cycle(acc);
            check("thru_in_ready", 128'(in_ready0), 128'(1));
            check("thru_out_valid", 128'(out_valid0), 128'(1));
        end
        in_valid = 1'b0;
        repeat (2) cycle(acc);

        // Stall with three words offered, then drain in order.
        emitted.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr = 32'h00100093; in_pc = 32'hA000; cycle(acc);
        in_instr = 32'h00200113; in_pc = 32'hB000; cycle(acc);
        check("full_in_ready", 128'(in_ready0), 128'(0));
        in_instr = 32'h00300193; in_pc = 32'hC000; cycle(acc);
        check("full_hold_in_ready", 128'(in_ready0), 128'(0));
        out_ready = 1'b1;
        cycle(acc);
        cycle(acc);
        in_valid = 1'b0;
        repeat (3) cycle(acc);
        check("order_count", 128'(emitted.size()), 128'(3));
        if (emitted.size() == 3) begin
            check("order_a", 128'(emitted[0]), 128'(32'hA000));
            check("order_b", 128'(emitted[1]), 128'(32'hB000));
            check("order_c", 128'(emitted[2]), 128'(32'hC000));
        end

        // Flush with a concurrent word while full: nothing ever emerges.
        emitted.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr = 32'h00400213; in_pc = 32'hD000; cycle(acc);
        in_instr = 32'h00500293; in_pc = 32'hD004; cycle(acc);
        flush = 1'b1;
        in_instr = 32'h00600313; in_pc = 32'hD008; cycle(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 128'(out_valid0), 128'(0));
        check("flush_in_ready", 128'(in_ready0), 128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            check("flush_no_word", 128'(out_valid0), 128'(0));
        end
        check("flush_emitted", 128'(emitted.size()), 128'(0));

        // Reset pulsed while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr = 32'h00700393; in_pc = 32'hE000; cycle(acc);
        in_instr = 32'h00800413; in_pc = 32'hE004; cycle(acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid0", 128'(out_valid0), 128'(0));
        check("midrst_out_valid1", 128'(out_valid1), 128'(0));
        check("midrst_in_ready", 128'(in_ready0), 128'(0));
        q0.delete();
        q1.delete();
        m_rdy = 1'b0;
        repeat (2) cycle(acc);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle(acc);
        check("midrst_rel_in_ready", 128'(in_ready0), 128'(1));
        check("midrst_rel_out_valid", 128'(out_valid0), 128'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 29) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            cycle(acc);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle(acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
